riscv_fetch: RTL and testbench

RISCV_FETCH -- requirements
Module: riscv_fetch

---
 rtl/riscv_fetch.sv | 145 ++++++++++++++
 tb/tb_riscv_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch.sv
// Instruction fetch unit: issues sequential reads to a 1-cycle-latency instruction RAM
// and queues returned words with their PCs in a small FIFO for decode.
module riscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_re_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic        fault_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_r;
    logic [31:0]        pc_r;
    logic [31:0]        inflight_pc_r;
    logic               inflight_r;
    logic               fault_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [31:0]        inst_mem_r [DEPTH];
    logic [31:0]        pc_mem_r   [DEPTH];

    logic               valid_s;
    logic               pop_s;
    logic               push_s;
    logic               issue_s;
    logic               redirect_s;
    logic               misaligned_s;
    logic [CNT_W:0]     occ_s;
    logic [CNT_W:0]     lim_s;

    // Handshake, issue and redirect decode; reset forces every output quiet.
    always_comb begin
        valid_s      = (count_r != {CNT_W{1'b0}}) && !reset;
        pop_s        = valid_s && inst_ready_i;
        redirect_s   = (state_r == RUN) && redirect_i && !reset;
        misaligned_s = redirect_s && (redirect_pc_i[1:0] != 2'b00);
        push_s       = inflight_r && !redirect_s;
        // An issue must leave room for itself after counting the response already in flight.
        occ_s        = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
        lim_s        = DEPTH_L + {{CNT_W{1'b0}}, pop_s};
        issue_s      = !reset && (state_r == RUN) && !redirect_i && (occ_s < lim_s);
    end

    // Output drive: request address and head entry are zero whenever not valid.
    always_comb begin
        mem_re_o     = issue_s;
        inst_valid_o = valid_s;
        fault_o      = fault_r && !reset;
        if (issue_s) begin
            mem_addr_o = pc_r;
        end else begin
            mem_addr_o = 32'h0000_0000;
        end
        if (valid_s) begin
            inst_o    = inst_mem_r[rd_ptr_r];
            inst_pc_o = pc_mem_r[rd_ptr_r];
        end else begin
            inst_o    = 32'h0000_0000;
            inst_pc_o = 32'h0000_0000;
        end
    end

    // FSM, fetch pointer, in-flight tracking and buffer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            inflight_pc_r <= 32'h0000_0000;
            inflight_r    <= 1'b0;
            fault_r       <= 1'b0;
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
            end
        end else begin
            case (state_r)
                IDLE: state_r <= RUN;
                RUN: begin
                    if (misaligned_s) begin
                        state_r <= HALT;
                        fault_r <= 1'b1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                HALT:    state_r <= HALT;
                default: state_r <= IDLE;
            endcase

            if (redirect_s) begin
                // Redirect wins over push/pop: flush queue and forget the outstanding response.
                count_r    <= {CNT_W{1'b0}};
                wr_ptr_r   <= {PTR_W{1'b0}};
                rd_ptr_r   <= {PTR_W{1'b0}};
                inflight_r <= 1'b0;
                if (!misaligned_s) begin
                    pc_r <= redirect_pc_i;
                end
            end else begin
                inflight_r <= issue_s;
                if (issue_s) begin
                    inflight_pc_r <= pc_r;
                    pc_r          <= pc_r + 32'd4;
                end
                if (push_s) begin
                    inst_mem_r[wr_ptr_r] <= mem_data_i;
                    pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
                    wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: startup, stall/drain, redirect, PC wrap, misaligned fault,
// and reset in the middle of a transfer.
module tb_riscv_fetch;

    logic        clk;
    logic        reset;
    logic        mem_re_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic        fault_o;

    int n_vec;
    int n_miss;

    riscv_fetch #(
        .RESET_PC (32'h0000_0100),
        .DEPTH    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_re_o      (mem_re_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_i    (mem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i),
        .fault_o       (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        return addr + 32'h1000_0000;
    endfunction

    // RAM model: word valid the cycle after a request, junk otherwise.
    always @(posedge clk) begin
        mem_data_i <= mem_re_o ? ram_word(mem_addr_o) : 32'hBAD0_BAD0;
    end

    task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_cycle(input string tag, input logic re_e, input logic [31:0] addr_e,
                             input logic v_e, input logic [31:0] pc_e);
        chk_vec({tag, ".re"},    {31'd0, mem_re_o},     {31'd0, re_e});
        chk_vec({tag, ".addr"},  mem_addr_o,            addr_e);
        chk_vec({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, v_e});
        if (v_e) begin
            chk_vec({tag, ".pc"},   inst_pc_o, pc_e);
            chk_vec({tag, ".inst"}, inst_o,    ram_word(pc_e));
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk_vec({tag, ".re"},    {31'd0, mem_re_o},     32'd0);
        chk_vec({tag, ".addr"},  mem_addr_o,            32'd0);
        chk_vec({tag, ".valid"}, {31'd0, inst_valid_o}, 32'd0);
        chk_vec({tag, ".inst"},  inst_o,                32'd0);
        chk_vec({tag, ".pc"},    inst_pc_o,             32'd0);
        chk_vec({tag, ".fault"}, {31'd0, fault_o},      32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] p;
        n_vec         = 0;
        n_miss        = 0;
        reset         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0000_0000;
        inst_ready_i  = 1'b1;

        repeat (3) next_cycle();
        sample();
        chk_quiet("rst");

        // Startup: IDLE cycle, then back-to-back issue from 0x100
        next_cycle();
        reset = 1'b0;
        sample();
        chk_cycle("idle", 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            sample();
            a = 32'h0000_0100 + 32'(k * 4);
            p = 32'h0000_0100 + 32'(k * 4) - 32'd8;
            chk_cycle("run", 1'b1, a, k >= 2, p);
        end

        // Decode stalls 10 cycles: two more issues fill the 4-entry buffer, head held
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            inst_ready_i = 1'b0;
            sample();
            a = (k < 2) ? 32'h0000_0120 + 32'(k * 4) : 32'h0;
            chk_cycle("stall", k < 2, a, 1'b1, 32'h0000_0118);
        end

        // Drain in order while fetching continues without a gap
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            inst_ready_i = 1'b1;
            sample();
            chk_cycle("drain", 1'b1, 32'h0000_0128 + 32'(k * 4), 1'b1, 32'h0000_0118 + 32'(k * 4));
        end

        // Redirect with three entries buffered and 0x13C in flight
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_2000;
        sample();
        chk_cycle("redir0", 1'b0, 32'h0, 1'b1, 32'h0000_0130);
        next_cycle();
        redirect_i = 1'b0;
        sample();
        chk_cycle("redir1", 1'b1, 32'h0000_2000, 1'b0, 32'h0);
        next_cycle();
        sample();
        chk_cycle("redir2", 1'b1, 32'h0000_2004, 1'b0, 32'h0);
        next_cycle();
        sample();
        chk_cycle("redir3", 1'b1, 32'h0000_2008, 1'b1, 32'h0000_2000);
        next_cycle();
        sample();
        chk_cycle("redir4", 1'b1, 32'h0000_200C, 1'b1, 32'h0000_2004);

        // PC wrap past the top of the address space
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        sample();
        chk_vec("wrap0.re", {31'd0, mem_re_o}, 32'd0);
        next_cycle();
        redirect_i = 1'b0;
        sample();
        chk_cycle("wrap1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        next_cycle();
        sample();
        chk_cycle("wrap2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        next_cycle();
        sample();
        chk_cycle("wrap3", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8);
        next_cycle();
        sample();
        chk_cycle("wrap4", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
        next_cycle();
        sample();
        chk_cycle("wrap5", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);

        // Misaligned redirect: sticky fault, fetch stops for good
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_2002;
        sample();
        chk_vec("mis0.re",    {31'd0, mem_re_o}, 32'd0);
        chk_vec("mis0.fault", {31'd0, fault_o},  32'd0);
        next_cycle();
        redirect_i = 1'b0;
        sample();
        chk_vec("mis1.fault", {31'd0, fault_o},      32'd1);
        chk_vec("mis1.valid", {31'd0, inst_valid_o}, 32'd0);
        chk_vec("mis1.re",    {31'd0, mem_re_o},     32'd0);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            redirect_i    = (k == 2);
            redirect_pc_i = 32'h0000_3000;
            inst_ready_i  = k[0];
            sample();
            chk_vec("halt.re",    {31'd0, mem_re_o},     32'd0);
            chk_vec("halt.valid", {31'd0, inst_valid_o}, 32'd0);
            chk_vec("halt.fault", {31'd0, fault_o},      32'd1);
        end

        // Reset leaves HALT; then reset again one cycle after an issue
        next_cycle();
        reset        = 1'b1;
        redirect_i   = 1'b0;
        inst_ready_i = 1'b1;
        sample();
        chk_quiet("rst2");
        next_cycle();
        reset = 1'b0;
        sample();
        chk_cycle("idle2", 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        sample();
        chk_cycle("iss2", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        next_cycle();
        reset = 1'b1;
        sample();
        chk_quiet("rstmid");
        next_cycle();
        sample();
        next_cycle();
        reset = 1'b0;
        sample();
        chk_cycle("post0", 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        sample();
        chk_cycle("post1", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        next_cycle();
        sample();
        chk_cycle("post2", 1'b1, 32'h0000_0104, 1'b0, 32'h0);
        next_cycle();
        sample();
        chk_cycle("post3", 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100);
        next_cycle();
        sample();
        chk_cycle("post4", 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0104);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
